freq_monitor: RTL and testbench



---
 rtl/freq_monitor_pkg.sv | 12 +
 rtl/freq_monitor_sync_edge_det.sv | 35 +++
 rtl/freq_monitor.sv | 158 +++++++++++++++
 tb/tb_freq_monitor.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_monitor_pkg.sv
// Shared FSM state type and synchroniser depth for the frequency monitor.
package freq_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/freq_monitor_sync_edge_det.sv
// Brings the asynchronous measured signal into the clk domain and emits a
// one-cycle pulse for each synchronised rising edge.
module sync_edge_det
    import freq_monitor_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Only the last synchroniser stage is trusted; the history flop lags it by one cycle.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_monitor.sv
// Counts sig_in rising edges over a fixed window of clk cycles and raises low/high/dead alarms.
// Optional macro FREQ_MONITOR_STICKY_EN adds a latched alarm_sticky output with alarm_clr.
module freq_monitor
    import freq_monitor_pkg::*;
#(
    parameter int GATE_CYCLES = 50000,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sig_in,
    input  logic [COUNT_WIDTH-1:0] min_thresh,
    input  logic [COUNT_WIDTH-1:0] max_thresh,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   freq_valid,
    output logic                   alarm_low,
    output logic                   alarm_high,
    output logic                   clk_dead
`ifdef FREQ_MONITOR_STICKY_EN
    ,
    output logic                   alarm_sticky,
    input  logic                   alarm_clr
`endif
);

    localparam int                     GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_e                 state_q, state_d;
    logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [COUNT_WIDTH-1:0] freq_count_q, freq_count_d;
    logic                   freq_valid_q, freq_valid_d;
    logic                   alarm_low_q, alarm_low_d;
    logic                   alarm_high_q, alarm_high_d;
    logic                   clk_dead_q, clk_dead_d;

    logic                   rise;
    logic                   counting;
    logic                   terminal;
    logic                   window_done;
    logic [COUNT_WIDTH-1:0] edge_next;

    sync_edge_det u_sync_edge_det (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WARMUP;
                WARMUP:  if (terminal) state_d = MEASURE;
                MEASURE: state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        counting    = enable && (state_q != IDLE);
        terminal    = (gate_cnt_q == GATE_LAST);
        window_done = counting && terminal && (state_q == MEASURE);
    end

    // A rise on the terminal cycle is folded into the closing window's result.
    always_comb begin
        edge_next = (edge_cnt_q == COUNT_MAX) ? COUNT_MAX : edge_cnt_q + COUNT_WIDTH'(rise);
    end

    always_comb begin
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        freq_count_d = freq_count_q;
        freq_valid_d = 1'b0;
        alarm_low_d  = alarm_low_q;
        alarm_high_d = alarm_high_q;
        clk_dead_d   = clk_dead_q;
        if (counting) begin
            gate_cnt_d = terminal ? '0 : gate_cnt_q + GATE_W'(1);
            edge_cnt_d = terminal ? '0 : edge_next;
        end
        if (window_done) begin
            freq_count_d = edge_next;
            freq_valid_d = 1'b1;
            alarm_low_d  = edge_next < min_thresh;
            alarm_high_d = edge_next > max_thresh;
            clk_dead_d   = edge_next == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            freq_count_q <= '0;
            freq_valid_q <= 1'b0;
            alarm_low_q  <= 1'b0;
            alarm_high_q <= 1'b0;
            clk_dead_q   <= 1'b0;
        end else begin
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            freq_count_q <= freq_count_d;
            freq_valid_q <= freq_valid_d;
            alarm_low_q  <= alarm_low_d;
            alarm_high_q <= alarm_high_d;
            clk_dead_q   <= clk_dead_d;
        end
    end

    assign freq_count = freq_count_q;
    assign freq_valid = freq_valid_q;
    assign alarm_low  = alarm_low_q;
    assign alarm_high = alarm_high_q;
    assign clk_dead   = clk_dead_q;

`ifdef FREQ_MONITOR_STICKY_EN
    logic alarm_sticky_q, alarm_sticky_d;

    // A new alarm reported in the same cycle as a clear request keeps the flag set.
    always_comb begin
        alarm_sticky_d = alarm_sticky_q;
        if (alarm_clr) begin
            alarm_sticky_d = 1'b0;
        end
        if (freq_valid_q && (alarm_low_q || alarm_high_q || clk_dead_q)) begin
            alarm_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_sticky_q <= 1'b0;
        end else begin
            alarm_sticky_q <= alarm_sticky_d;
        end
    end

    assign alarm_sticky = alarm_sticky_q;
`endif

endmodule

// File: tb/tb_freq_monitor.sv
// Bench for freq_monitor: directed and random sig_in patterns checked against a rise-counting model.
// Define FREQ_MONITOR_STICKY_EN to also exercise the sticky alarm.
module tb_freq_monitor;

    localparam int GATE    = 100;
    localparam int CW      = 16;
    localparam int CW_SAT  = 4;
    localparam int MAX_CNT = (1 << CW) - 1;
    localparam int MAX_SAT = (1 << CW_SAT) - 1;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          enable     = 1'b0;
    logic          sig_in     = 1'b0;
    logic [CW-1:0] min_thresh = '0;
    logic [CW-1:0] max_thresh = '0;
    logic [CW-1:0] freq_count;
    logic          freq_valid, alarm_low, alarm_high, clk_dead;
    logic [CW_SAT-1:0] sat_count;
    logic          sat_valid, sat_low, sat_high, sat_dead;
`ifdef FREQ_MONITOR_STICKY_EN
    logic          alarm_sticky, sat_sticky;
    logic          alarm_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freq_monitor #(.GATE_CYCLES(GATE), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .min_thresh (min_thresh),
        .max_thresh (max_thresh),
        .freq_count (freq_count),
        .freq_valid (freq_valid),
        .alarm_low  (alarm_low),
        .alarm_high (alarm_high),
        .clk_dead   (clk_dead)
`ifdef FREQ_MONITOR_STICKY_EN
        ,
        .alarm_sticky (alarm_sticky),
        .alarm_clr    (alarm_clr)
`endif
    );

    freq_monitor #(.GATE_CYCLES(GATE), .COUNT_WIDTH(CW_SAT)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sig_in     (sig_in),
        .min_thresh (min_thresh[CW_SAT-1:0]),
        .max_thresh (max_thresh[CW_SAT-1:0]),
        .freq_count (sat_count),
        .freq_valid (sat_valid),
        .alarm_low  (sat_low),
        .alarm_high (sat_high),
        .clk_dead   (sat_dead)
`ifdef FREQ_MONITOR_STICKY_EN
        ,
        .alarm_sticky (sat_sticky),
        .alarm_clr    (alarm_clr)
`endif
    );

    typedef enum int {M_CONST, M_PERIODIC, M_RANDOM, M_PULSES} mode_e;
    mode_e mode        = M_CONST;
    int    period      = 10;
    int    phase       = 0;
    int    pulse_a     = -100;
    int    pulse_b     = -100;
    logic  const_level = 1'b0;

    // Edge 0 is the clk edge that first samples enable high; samp[t] is sig_in seen at edge t.
    int         edge_idx = 0;
    logic       samp[$];
    int         v_edge[$];
    int         v_count[$];
    logic [2:0] v_flags[$];
    int         v_sat[$];

    function automatic logic gen_sig(int t);
        case (mode)
            M_PERIODIC: return logic'(((t + phase) % period) < (period / 2));
            M_RANDOM:   return logic'($urandom_range(0, 1));
            M_PULSES:   return logic'((t >= pulse_a && t < pulse_a + 4) || (t >= pulse_b && t < pulse_b + 4));
            default:    return const_level;
        endcase
    endfunction

    // Window k (k>=1) reports after edge (k+1)*GATE and holds every sampled 0->1 transition
    // of sig_in at edges k*GATE-1 .. (k+1)*GATE-2 (three clocks from sig_in to the count).
    function automatic int model_count(int k, int maxv);
        int n = 0;
        for (int j = k * GATE - 1; j <= (k + 1) * GATE - 2; j++) begin
            if (samp[j] && !samp[j-1]) n++;
        end
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic logic [2:0] exp_flags(int cnt);
        return {logic'(cnt < int'(min_thresh)), logic'(cnt > int'(max_thresh)), logic'(cnt == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        samp.push_back(sig_in);
        #1;
        if (freq_valid === 1'b1) begin
            v_edge.push_back(edge_idx);
            v_count.push_back(int'(freq_count));
            v_flags.push_back({alarm_low, alarm_high, clk_dead});
            v_sat.push_back(int'(sat_count));
        end
        edge_idx++;
        sig_in = gen_sig(edge_idx);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic clear_trace();
        samp.delete();
        v_edge.delete();
        v_count.delete();
        v_flags.delete();
        v_sat.delete();
        edge_idx = 0;
    endtask

    task automatic start_measure();
        clear_trace();
        enable = 1'b1;
        sig_in = gen_sig(0);
    endtask

    task automatic stop_measure();
        enable = 1'b0;
        run(5);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (freq_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", freq_count);
        end
        checks++;
        if ({freq_valid, alarm_low, alarm_high, clk_dead} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {freq_valid, alarm_low, alarm_high, clk_dead});
        end
`ifdef FREQ_MONITOR_STICKY_EN
        checks++;
        if (alarm_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_sticky: got %b expected 0", alarm_sticky);
        end
`endif
        reset = 1'b0;
        clear_trace();
        run(2 * GATE + 10);
        checks++;
        if (v_edge.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_no_valid: got %0d pulses expected 0", v_edge.size());
        end
    endtask

    task automatic test_nominal();
        int exp;
        int got;
        mode = M_PERIODIC;
        period = 10;
        phase = $urandom_range(0, 9);
        min_thresh = 8;
        max_thresh = 12;
        start_measure();
        run(2 * GATE);
        checks++;
        if (v_edge.size() != 0) begin
            errors++;
            $display("[TB] FAIL nominal_early_valid: got %0d pulses expected 0", v_edge.size());
        end
        run(1);
        got = (v_edge.size() > 0) ? v_edge[0] : -1;
        checks++;
        if (got != 2 * GATE) begin
            errors++;
            $display("[TB] FAIL nominal_first_valid: got edge %0d expected %0d", got, 2 * GATE);
        end
        run(2 * GATE);
        checks++;
        if (v_edge.size() != 3) begin
            errors++;
            $display("[TB] FAIL nominal_windows: got %0d expected 3", v_edge.size());
        end
        for (int k = 1; k <= 3 && k <= v_edge.size(); k++) begin
            exp = model_count(k, MAX_CNT);
            checks++;
            if (v_edge[k-1] != (k + 1) * GATE) begin
                errors++;
                $display("[TB] FAIL nominal_edge_w%0d: got %0d expected %0d", k, v_edge[k-1], (k + 1) * GATE);
            end
            checks++;
            if (v_count[k-1] != exp) begin
                errors++;
                $display("[TB] FAIL nominal_count_w%0d: got %0d expected %0d", k, v_count[k-1], exp);
            end
            checks++;
            if (v_flags[k-1] !== exp_flags(exp)) begin
                errors++;
                $display("[TB] FAIL nominal_flags_w%0d: got %b expected %b", k, v_flags[k-1], exp_flags(exp));
            end
        end
        stop_measure();
    endtask

    task automatic test_dead();
        int exp;
        mode = M_CONST;
        const_level = 1'b0;
        min_thresh = 8;
        max_thresh = 12;
        start_measure();
        run(2 * GATE + 1);
        checks++;
        if (v_edge.size() != 1) begin
            errors++;
            $display("[TB] FAIL dead_windows: got %0d expected 1", v_edge.size());
        end else begin
            exp = model_count(1, MAX_CNT);
            checks++;
            if (v_count[0] != exp) begin
                errors++;
                $display("[TB] FAIL dead_count: got %0d expected %0d", v_count[0], exp);
            end
            checks++;
            if (v_flags[0] !== exp_flags(exp)) begin
                errors++;
                $display("[TB] FAIL dead_flags: got %b expected %b", v_flags[0], exp_flags(exp));
            end
        end
        stop_measure();
    endtask

    task automatic test_high();
        int exp;
        mode = M_PERIODIC;
        period = 4;
        phase = $urandom_range(0, 3);
        min_thresh = 8;
        max_thresh = 20;
        start_measure();
        run(3 * GATE + 1);
        checks++;
        if (v_edge.size() != 2) begin
            errors++;
            $display("[TB] FAIL high_windows: got %0d expected 2", v_edge.size());
        end
        for (int k = 1; k <= 2 && k <= v_edge.size(); k++) begin
            exp = model_count(k, MAX_CNT);
            checks++;
            if (v_count[k-1] != exp) begin
                errors++;
                $display("[TB] FAIL high_count_w%0d: got %0d expected %0d", k, v_count[k-1], exp);
            end
            checks++;
            if (v_flags[k-1] !== exp_flags(exp)) begin
                errors++;
                $display("[TB] FAIL high_flags_w%0d: got %b expected %b", k, v_flags[k-1], exp_flags(exp));
            end
            exp = model_count(k, MAX_SAT);
            checks++;
            if (v_sat[k-1] != exp) begin
                errors++;
                $display("[TB] FAIL sat_count_w%0d: got %0d expected %0d", k, v_sat[k-1], exp);
            end
        end
        stop_measure();
    endtask

    task automatic test_terminal_edge();
        int exp;
        mode = M_PULSES;
        pulse_a = 2 * GATE - 2;
        pulse_b = 3 * GATE - 1;
        min_thresh = 0;
        max_thresh = 5;
        start_measure();
        run(4 * GATE + 1);
        checks++;
        if (v_edge.size() != 3) begin
            errors++;
            $display("[TB] FAIL term_windows: got %0d expected 3", v_edge.size());
        end
        for (int k = 1; k <= 3 && k <= v_edge.size(); k++) begin
            exp = model_count(k, MAX_CNT);
            checks++;
            if (v_count[k-1] != exp) begin
                errors++;
                $display("[TB] FAIL term_count_w%0d: got %0d expected %0d", k, v_count[k-1], exp);
            end
        end
        stop_measure();
    endtask

    task automatic test_random();
        int exp;
        for (int rep = 0; rep < 2; rep++) begin
            mode = M_RANDOM;
            min_thresh = CW'($urandom_range(15, 35));
            max_thresh = CW'($urandom_range(15, 35));
            start_measure();
            run(4 * GATE + 1);
            checks++;
            if (v_edge.size() != 3) begin
                errors++;
                $display("[TB] FAIL random_windows: got %0d expected 3", v_edge.size());
            end
            for (int k = 1; k <= 3 && k <= v_edge.size(); k++) begin
                exp = model_count(k, MAX_CNT);
                checks++;
                if (v_count[k-1] != exp) begin
                    errors++;
                    $display("[TB] FAIL random_count_w%0d: got %0d expected %0d", k, v_count[k-1], exp);
                end
                checks++;
                if (v_flags[k-1] !== exp_flags(exp)) begin
                    errors++;
                    $display("[TB] FAIL random_flags_w%0d: got %b expected %b", k, v_flags[k-1], exp_flags(exp));
                end
            end
            stop_measure();
        end
    endtask

    task automatic test_enable_drop();
        int exp;
        int got;
        mode = M_PERIODIC;
        period = 10;
        phase = $urandom_range(0, 9);
        min_thresh = 8;
        max_thresh = 12;
        start_measure();
        run(2 * GATE + 41);
        exp = model_count(1, MAX_CNT);
        enable = 1'b0;
        run(2 * GATE + 50);
        checks++;
        if (v_edge.size() != 1) begin
            errors++;
            $display("[TB] FAIL drop_no_valid: got %0d pulses expected 1", v_edge.size());
        end
        checks++;
        if (int'(freq_count) != exp) begin
            errors++;
            $display("[TB] FAIL drop_hold_count: got %0d expected %0d", freq_count, exp);
        end
        checks++;
        if ({alarm_low, alarm_high, clk_dead} !== exp_flags(exp)) begin
            errors++;
            $display("[TB] FAIL drop_hold_flags: got %b expected %b", {alarm_low, alarm_high, clk_dead}, exp_flags(exp));
        end
        start_measure();
        run(2 * GATE);
        checks++;
        if (v_edge.size() != 0) begin
            errors++;
            $display("[TB] FAIL drop_early_valid: got %0d pulses expected 0", v_edge.size());
        end
        run(1);
        got = (v_edge.size() > 0) ? v_edge[0] : -1;
        checks++;
        if (got != 2 * GATE) begin
            errors++;
            $display("[TB] FAIL drop_rewarm_valid: got edge %0d expected %0d", got, 2 * GATE);
        end
        stop_measure();
    endtask

    task automatic test_reset_mid();
        int exp;
        int got;
        mode = M_RANDOM;
        min_thresh = 20;
        max_thresh = 30;
        start_measure();
        run(2 * GATE + 31);
        reset = 1'b1;
        run(3);
        checks++;
        if (freq_count !== '0 || sat_count !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d/%0d expected 0/0", freq_count, sat_count);
        end
        checks++;
        if ({freq_valid, alarm_low, alarm_high, clk_dead} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got %b expected 0000", {freq_valid, alarm_low, alarm_high, clk_dead});
        end
        reset = 1'b0;
        start_measure();
        run(2 * GATE);
        checks++;
        if (v_edge.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_early_valid: got %0d pulses expected 0", v_edge.size());
        end
        run(1);
        got = (v_edge.size() > 0) ? v_edge[0] : -1;
        checks++;
        if (got != 2 * GATE) begin
            errors++;
            $display("[TB] FAIL midreset_valid: got edge %0d expected %0d", got, 2 * GATE);
        end else begin
            exp = model_count(1, MAX_CNT);
            checks++;
            if (v_count[0] != exp) begin
                errors++;
                $display("[TB] FAIL midreset_count_w1: got %0d expected %0d", v_count[0], exp);
            end
        end
        stop_measure();
    endtask

`ifdef FREQ_MONITOR_STICKY_EN
    task automatic test_sticky();
        mode = M_CONST;
        const_level = 1'b0;
        min_thresh = 8;
        max_thresh = 12;
        alarm_clr = 1'b0;
        start_measure();
        run(2 * GATE + 3);
        run(GATE);
        checks++;
        if (alarm_sticky !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sticky_set: got %b expected 1", alarm_sticky);
        end
        alarm_clr = 1'b1;
        run(1);
        alarm_clr = 1'b0;
        run(2);
        checks++;
        if (alarm_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sticky_clear: got %b expected 0", alarm_sticky);
        end
        run(4 * GATE - edge_idx);
        alarm_clr = 1'b1;
        run(2);
        checks++;
        if (alarm_sticky !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sticky_set_wins: got %b expected 1", alarm_sticky);
        end
        alarm_clr = 1'b0;
        stop_measure();
    endtask
`endif

    initial begin
        $display("[TB] freq_monitor bench start");
        test_reset();
        test_nominal();
        test_dead();
        test_high();
        test_terminal_edge();
        test_random();
        test_enable_drop();
        test_reset_mid();
`ifdef FREQ_MONITOR_STICKY_EN
        test_sticky();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
